// File: rtl/pc_fetch_if.sv
// Bundle between the fetch controller, the next-PC logic, decode and the instruction memory.
// Read handshake: Imem_Rd is a one-cycle request at Imem_Addr; the memory answers later with a
// one-cycle Imem_Done carrying Imem_Data. Only a Done seen while a read is outstanding is used.
interface pc_fetch_if;
  logic [15:0] Nxt_PC;
  logic        Stall;
  logic        Halt;
  logic        Siic;
  logic [15:0] Imem_Data;
  logic        Imem_Done;
  logic        Imem_Rd;
  logic [15:0] Imem_Addr;
  logic [15:0] Curr_PC;
  logic [15:0] Instr;
  logic        Instr_Valid;
  logic [15:0] EPC;
  logic        Halted;
  logic        Align_Err;
  logic [15:0] Instr_Cnt;

  modport master (
    output Nxt_PC, Stall, Halt, Siic, Imem_Data, Imem_Done,
    input  Imem_Rd, Imem_Addr, Curr_PC, Instr, Instr_Valid, EPC, Halted, Align_Err, Instr_Cnt
  );

  modport slave (
    input  Nxt_PC, Stall, Halt, Siic, Imem_Data, Imem_Done,
    output Imem_Rd, Imem_Addr, Curr_PC, Instr, Instr_Valid, EPC, Halted, Align_Err, Instr_Cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC/EPC holder and fetch sequencer: FETCH issues a read, WAIT captures the word,
// EXEC retires it (halt, stall, exception or normal), HALT is terminal until reset.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  logic       clk,
  input  logic       rst,
  pc_fetch_if.slave  bus,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state_q,       state_d;
  logic [15:0] curr_pc_q,     curr_pc_d;
  logic [15:0] epc_q,         epc_d;
  logic [15:0] instr_q,       instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q,      halted_d;
  logic        align_err_q,   align_err_d;
  logic [15:0] instr_cnt_q,   instr_cnt_d;

  always_comb begin
    state_d       = state_q;
    curr_pc_d     = curr_pc_q;
    epc_d         = epc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    align_err_d   = align_err_q;
    instr_cnt_d   = instr_cnt_q;

    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.Imem_Done) begin
          instr_d       = bus.Imem_Data;
          instr_valid_d = 1'b1;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.Halt) begin
          halted_d      = 1'b1;
          instr_valid_d = 1'b0;
          instr_cnt_d   = instr_cnt_q + 16'd1;
          state_d       = S_HALT;
        end else if (!bus.Stall) begin
          instr_valid_d = 1'b0;
          instr_cnt_d   = instr_cnt_q + 16'd1;
          // An odd target is kept in Curr_PC so the faulting address is visible after the stop.
          if (bus.Nxt_PC[0]) begin
            align_err_d = 1'b1;
            halted_d    = 1'b1;
            curr_pc_d   = bus.Nxt_PC;
            state_d     = S_HALT;
          end else if (bus.Siic) begin
            epc_d     = bus.Nxt_PC;
            curr_pc_d = EXC_VECTOR;
            state_d   = S_FETCH;
          end else begin
            curr_pc_d = bus.Nxt_PC;
            state_d   = S_FETCH;
          end
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      curr_pc_q     <= RESET_PC;
      epc_q         <= 16'h0000;
      instr_q       <= 16'h0000;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      align_err_q   <= 1'b0;
      instr_cnt_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      curr_pc_q     <= curr_pc_d;
      epc_q         <= epc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      align_err_q   <= align_err_d;
      instr_cnt_q   <= instr_cnt_d;
    end
  end

  // No read request leaves the block while reset is held.
  assign bus.Imem_Rd     = (state_q == S_FETCH) && !rst;
  assign bus.Imem_Addr   = curr_pc_q;
  assign bus.Curr_PC     = curr_pc_q;
  assign bus.Instr       = instr_q;
  assign bus.Instr_Valid = instr_valid_q;
  assign bus.EPC         = epc_q;
  assign bus.Halted      = halted_q;
  assign bus.Align_Err   = align_err_q;
  assign bus.Instr_Cnt   = instr_cnt_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequencing, memory waits, stalls, exception,
// halt priority, misalignment, reset during an outstanding read and counter wrap.
module tb_pc_fetch_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  int         rd_cnt = 0;
  int         cyc;
  int         rd_mark;

  pc_fetch_if bus();

  pc_fetch_ctrl #(.RESET_PC(16'h0000), .EXC_VECTOR(16'h0002)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.Imem_Rd) rd_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check16(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.Stall = 1'b0; bus.Halt = 1'b0; bus.Siic = 1'b0;
    bus.Imem_Done = 1'b0; bus.Imem_Data = 16'h0000; bus.Nxt_PC = 16'h0000;
    step();
    step();
    check16("rst_state",  16'(state_dbg),       16'd0);
    check16("rst_pc",     bus.Curr_PC,          16'h0000);
    check16("rst_epc",    bus.EPC,              16'h0000);
    check16("rst_instr",  bus.Instr,            16'h0000);
    check16("rst_cnt",    bus.Instr_Cnt,        16'h0000);
    check16("rst_valid",  16'(bus.Instr_Valid), 16'd0);
    check16("rst_halted", 16'(bus.Halted),      16'd0);
    check16("rst_align",  16'(bus.Align_Err),   16'd0);
    check16("rst_rd",     16'(bus.Imem_Rd),     16'd0);
    rst = 1'b0;
    #1;
  endtask

  // One instruction from its FETCH cycle to the cycle after retire. A halting retire also
  // raises Stall and Siic so the halt priority is exercised.
  task automatic run_instr(input logic [15:0] pc, input logic [15:0] data, input int waits,
                           input int stalls, input logic [15:0] nxt, input logic siic,
                           input logic halt, output int cycles);
    cycles = 0;
    check16("fetch_rd",   16'(bus.Imem_Rd), 16'd1);
    check16("fetch_addr", bus.Imem_Addr,    pc);
    step(); cycles++;
    for (int i = 0; i < waits; i++) begin
      check16("wait_rd",    16'(bus.Imem_Rd),     16'd0);
      check16("wait_valid", 16'(bus.Instr_Valid), 16'd0);
      bus.Imem_Done = (i == waits - 1);
      bus.Imem_Data = data;
      step(); cycles++;
    end
    bus.Imem_Done = 1'b0;
    bus.Imem_Data = 16'h0000;
    check16("exec_valid", 16'(bus.Instr_Valid), 16'd1);
    check16("exec_instr", bus.Instr,            data);
    for (int i = 0; i < stalls; i++) begin
      bus.Stall = 1'b1; bus.Siic = siic; bus.Nxt_PC = nxt;
      step(); cycles++;
      check16("stall_state", 16'(state_dbg),   16'd2);
      check16("stall_instr", bus.Instr,        data);
      check16("stall_pc",    bus.Curr_PC,      pc);
      check16("stall_rd",    16'(bus.Imem_Rd), 16'd0);
    end
    bus.Stall = halt; bus.Siic = siic; bus.Halt = halt; bus.Nxt_PC = nxt;
    step(); cycles++;
    bus.Stall = 1'b0; bus.Siic = 1'b0; bus.Halt = 1'b0;
  endtask

  initial begin
    do_reset();

    // Back-to-back sequential fetch, Done one cycle after Rd
    for (int k = 0; k < 4; k++) begin
      run_instr(16'(2 * k), 16'hA000 + 16'(k), 1, 0, 16'(2 * k + 2), 1'b0, 1'b0, cyc);
      check16("seq_cycles", 16'(cyc), 16'd3);
    end
    check16("seq_cnt", bus.Instr_Cnt, 16'd4);
    check16("seq_pc",  bus.Curr_PC,   16'h0008);

    // Slow memory plus a three-cycle stall
    rd_mark = rd_cnt;
    run_instr(16'h0008, 16'hB00B, 6, 3, 16'h000A, 1'b0, 1'b0, cyc);
    check16("slow_cycles", 16'(cyc),                16'd11);
    check16("slow_rd_once", 16'(rd_cnt - rd_mark),  16'd1);
    check16("slow_pc",     bus.Curr_PC,             16'h000A);
    check16("slow_state",  16'(state_dbg),          16'd0);
    check16("slow_cnt",    bus.Instr_Cnt,           16'd5);

    // Software exception
    run_instr(16'h000A, 16'h1111, 1, 0, 16'h0010, 1'b0, 1'b0, cyc);
    run_instr(16'h0010, 16'h5115, 2, 1, 16'h0012, 1'b1, 1'b0, cyc);
    check16("siic_epc",   bus.EPC,              16'h0012);
    check16("siic_addr",  bus.Imem_Addr,        16'h0002);
    check16("siic_cnt",   bus.Instr_Cnt,        16'd7);
    check16("siic_valid", 16'(bus.Instr_Valid), 16'd0);

    // Halt beats Stall and Siic
    run_instr(16'h0002, 16'h2222, 1, 0, 16'h0020, 1'b0, 1'b0, cyc);
    run_instr(16'h0020, 16'hFEED, 1, 0, 16'h0024, 1'b1, 1'b1, cyc);
    check16("halt_halted", 16'(bus.Halted),      16'd1);
    check16("halt_pc",     bus.Curr_PC,          16'h0020);
    check16("halt_epc",    bus.EPC,              16'h0012);
    check16("halt_cnt",    bus.Instr_Cnt,        16'd9);
    check16("halt_valid",  16'(bus.Instr_Valid), 16'd0);
    check16("halt_state",  16'(state_dbg),       16'd3);
    rd_mark = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.Imem_Done = i[0]; bus.Halt = i[1]; bus.Siic = i[2]; bus.Nxt_PC = 16'(4 * i);
      step();
    end
    bus.Imem_Done = 1'b0; bus.Halt = 1'b0; bus.Siic = 1'b0;
    check16("halt_no_rd",  16'(rd_cnt - rd_mark), 16'd0);
    check16("halt_pc_hold", bus.Curr_PC,          16'h0020);
    check16("halt_cnt_hold", bus.Instr_Cnt,       16'd9);

    // Odd retire target
    do_reset();
    run_instr(16'h0000, 16'h3333, 1, 0, 16'h0030, 1'b0, 1'b0, cyc);
    run_instr(16'h0030, 16'h4444, 1, 0, 16'h0031, 1'b0, 1'b0, cyc);
    check16("align_err",    16'(bus.Align_Err), 16'd1);
    check16("align_halted", 16'(bus.Halted),    16'd1);
    check16("align_pc",     bus.Curr_PC,        16'h0031);
    check16("align_epc",    bus.EPC,            16'h0000);
    check16("align_cnt",    bus.Instr_Cnt,      16'd2);
    rd_mark = rd_cnt;
    for (int i = 0; i < 5; i++) step();
    check16("align_no_rd", 16'(rd_cnt - rd_mark), 16'd0);

    // Reset with a read outstanding; the late Done lands in FETCH and is dropped
    do_reset();
    check16("rw_fetch_addr", bus.Imem_Addr, 16'h0000);
    step();
    check16("rw_in_wait", 16'(state_dbg), 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; bus.Imem_Done = 1'b1; bus.Imem_Data = 16'hBAD1;
    #1;
    check16("rw_refetch_rd",   16'(bus.Imem_Rd), 16'd1);
    check16("rw_refetch_addr", bus.Imem_Addr,    16'h0000);
    step();
    bus.Imem_Done = 1'b0;
    check16("rw_stale_state", 16'(state_dbg),       16'd1);
    check16("rw_stale_valid", 16'(bus.Instr_Valid), 16'd0);
    check16("rw_stale_instr", bus.Instr,            16'h0000);
    check16("rw_cnt",         bus.Instr_Cnt,        16'h0000);
    bus.Imem_Done = 1'b1; bus.Imem_Data = 16'h1234;
    step();
    bus.Imem_Done = 1'b0;
    check16("rw_good_instr", bus.Instr, 16'h1234);
    bus.Nxt_PC = 16'h0004;
    step();

    // Counter and PC wrap; the counter is preset rather than walked through 65k retires
    force dut.instr_cnt_q = 16'hFFFE;
    #1;
    release dut.instr_cnt_q;
    run_instr(16'h0004, 16'h5555, 1, 0, 16'hFFFE, 1'b0, 1'b0, cyc);
    check16("wrap_cnt_ffff", bus.Instr_Cnt, 16'hFFFF);
    run_instr(16'hFFFE, 16'h6666, 1, 0, 16'h0000, 1'b0, 1'b0, cyc);
    check16("wrap_cnt_zero", bus.Instr_Cnt, 16'h0000);
    check16("wrap_pc",       bus.Curr_PC,   16'h0000);
    check16("wrap_addr",     bus.Imem_Addr, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Holds the architectural PC and the EPC register, and runs instruction fetch against a multi-cycle instruction memory.
- Sits directly downstream of the next-PC logic. It consumes Nxt_PC each time an instruction retires and feeds Curr_PC back to that logic.
- EPC is exported to the next-PC logic, which uses it for the return-from-exception code.
- Also provides HALT handling, stall hold, misalignment detection and a retired-instruction counter.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- EXC_VECTOR, 16'h0002, PC loaded when Siic retires.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Nxt_PC  in  16  next PC from the next-PC logic; sampled only at retire.
- Stall  in  1  hazard stall from decode; holds the current instruction.
- Halt  in  1  current instruction is HALT.
- Siic  in  1  current instruction is SIIC (software exception).
- Imem_Data  in  16  instruction word; valid only while Imem_Done=1.
- Imem_Done  in  1  memory read completed.
- Imem_Rd  out  1  read request, single-cycle pulse.
- Imem_Addr  out  16  read address; equals Curr_PC.
- Curr_PC  out  16  PC of the instruction being fetched or held.
- Instr  out  16  captured instruction word.
- Instr_Valid  out  1  Instr is valid for decode.
- EPC  out  16  saved exception return PC.
- Halted  out  1  processor halted, sticky.
- Align_Err  out  1  odd retire address seen, sticky.
- Instr_Cnt  out  16  count of retired instructions.

Behaviour:
- Reset (rst=1 at an edge, in any state):
  - State goes to FETCH; Curr_PC=RESET_PC.
  - EPC, Instr and Instr_Cnt are 0; Instr_Valid, Halted, Align_Err and Imem_Rd are 0.
  - Reset overrides every other input in that cycle.
- States: FETCH, WAIT, EXEC, HALT. State is encoded in a register; all outputs are registered or decoded from state.
- FETCH:
  - Imem_Rd=1 and Imem_Addr=Curr_PC for exactly this one cycle.
  - Next state is WAIT unconditionally.
  - Imem_Done in this cycle is ignored (stale response, e.g. one issued before reset).
- WAIT:
  - Imem_Rd=0.
  - When Imem_Done=1: Instr<=Imem_Data, Instr_Valid<=1, go to EXEC.
  - Otherwise stay in WAIT. There is no timeout.
- EXEC: Instr_Valid=1. Decision priority is Halt > Stall > Siic > normal.
  - Halt=1: go to HALT; Halted<=1; Instr_Valid<=0; Instr_Cnt increments; Curr_PC holds.
  - Stall=1: stay in EXEC; Curr_PC, Instr and Instr_Cnt hold.
  - Siic=1: EPC<=Nxt_PC; Curr_PC<=EXC_VECTOR; Instr_Valid<=0; Instr_Cnt increments; go to FETCH.
  - Normal: Curr_PC<=Nxt_PC; Instr_Valid<=0; Instr_Cnt increments; go to FETCH.
  - Nxt_PC[0]=1 on a Siic or normal retire: Align_Err<=1; Halted<=1; Curr_PC<=Nxt_PC (recorded for debug); go to HALT. EPC is not written. Instr_Cnt still increments.
- HALT:
  - Terminal state; all outputs hold and Imem_Rd=0.
  - Exit is by rst only.
- Input qualification: Halt, Stall and Siic are ignored outside EXEC. Imem_Done is ignored outside WAIT.
- Arithmetic:
  - Instr_Cnt is 16-bit and wraps FFFF->0000.
  - Curr_PC is loaded verbatim, so Nxt_PC wrap (e.g. FFFE->0000) is accepted as-is.
- Latency:
  - Minimum 3 cycles per instruction: FETCH, WAIT with Done, EXEC with no stall.
  - Each extra memory wait cycle or stall cycle adds one cycle.
- Reset in WAIT with a read outstanding: the next state is FETCH at RESET_PC, and the late Done is ignored because it arrives in FETCH.

Test Plan:
- Reset, memory Done 1 cycle after Rd, Nxt_PC=Curr_PC+2 every retire, 4 instructions -> Imem_Addr sequence 0000,0002,0004,0006; each instruction 3 cycles; Instr_Cnt=4.
- Memory returns Done after 5 WAIT cycles; Stall held 3 cycles in EXEC -> Instr and Curr_PC stable throughout; Imem_Rd pulses exactly once per instruction; retire occurs the cycle Stall drops.
- Siic in EXEC at Curr_PC=0010 with Nxt_PC=0012 -> EPC=0012, next Imem_Addr=0002, Instr_Cnt increments by 1.
- Halt with Stall and Siic also asserted at Curr_PC=0020 -> Halted=1, Curr_PC=0020, EPC unchanged; no further Imem_Rd for 20 cycles.
- Nxt_PC=0031 at retire -> Align_Err=1, Halted=1, Curr_PC=0031, no further fetch.
- rst pulsed in WAIT, Done arrives the cycle after rst -> that response is ignored, fetch restarts at 0000, Instr_Cnt=0; also preload Instr_Cnt=FFFF via retires -> next retire gives 0000.
